// File: rtl/fact_sequencer_if.sv
// Handshake bundle between the FACT sequencer, the CU start/result lines and the
// shared ALU multiply port. The sequencer uses the master view (it issues multiply
// requests); the CU/ALU side uses the slave view.
interface fact_sequencer_if #(
  parameter int unsigned W = 16
);
  // CU side
  logic         fact;
  logic [W-1:0] operand;
  logic         fact_end;
  logic [W-1:0] result;
  logic         ovf;
  logic         err;
  logic         busy;
  // ALU multiply port
  logic         mul_req;
  logic [W-1:0] mul_a;
  logic [W-1:0] mul_b;
  logic         mul_ack;
  logic [W-1:0] mul_result;
  logic         mul_ovf;

  modport master (
    input  fact,
    input  operand,
    input  mul_ack,
    input  mul_result,
    input  mul_ovf,
    output mul_req,
    output mul_a,
    output mul_b,
    output fact_end,
    output result,
    output ovf,
    output err,
    output busy
  );

  modport slave (
    output fact,
    output operand,
    output mul_ack,
    output mul_result,
    output mul_ovf,
    input  mul_req,
    input  mul_a,
    input  mul_b,
    input  fact_end,
    input  result,
    input  ovf,
    input  err,
    input  busy
  );
endinterface

// File: rtl/fact_sequencer.sv
// FACT instruction sequencer: computes n! by repeated requests to the shared ALU
// multiplier (acc * cnt, cnt counting down to 2). Moore outputs only; the multiply
// port is driven only while in the multiply state.
module fact_sequencer #(
  parameter int unsigned W       = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  fact_sequencer_if.master bus
);

  localparam int unsigned     TmoW    = $clog2(TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoop,
    StMul,
    StDone,
    StHold
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [W-1:0]    result_q, result_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;

  // State and datapath registers; reset releases the multiplier immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  // Next-state and datapath update; a dropped FACT in LOOP/MUL wins over everything.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    err_d    = err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.fact) begin
          acc_d   = W'(1);
          cnt_d   = bus.operand;
          tmo_d   = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = StLoop;
        end
      end

      StLoop: begin
        if (!bus.fact) begin
          state_d = StIdle;
        end else if (cnt_q <= W'(1)) begin
          // acc is frozen from here to DONE, so latching it on entry makes RESULT
          // valid in the same cycle as the FACT_END pulse.
          result_d = acc_q;
          state_d  = StDone;
        end else begin
          tmo_d   = '0;
          state_d = StMul;
        end
      end

      StMul: begin
        if (!bus.fact) begin
          state_d = StIdle;
        end else if (bus.mul_ack) begin
          acc_d   = bus.mul_result;
          ovf_d   = ovf_q | bus.mul_ovf;
          cnt_d   = cnt_q - W'(1);
          tmo_d   = '0;
          state_d = StLoop;
        end else if (tmo_q == TmoLast) begin
          // Abort: report the partial product with ERR set.
          err_d    = 1'b1;
          tmo_d    = '0;
          result_d = acc_q;
          state_d  = StDone;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end

      StDone: begin
        state_d = StHold;
      end

      StHold: begin
        // Wait for the CU to release FACT so a held level cannot retrigger.
        if (!bus.fact) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from state and registers only.
  always_comb begin
    bus.mul_req  = (state_q == StMul);
    bus.mul_a    = (state_q == StMul) ? acc_q : '0;
    bus.mul_b    = (state_q == StMul) ? cnt_q : '0;
    bus.fact_end = (state_q == StDone);
    bus.busy     = (state_q == StLoop) || (state_q == StMul);
    bus.result   = result_q;
    bus.ovf      = ovf_q;
    bus.err      = err_q;
  end

endmodule

// File: tb/tb_fact_sequencer.sv
// Bench for fact_sequencer: a behavioural ALU multiplier with configurable ack
// latency, a table of hand-computed runs, hand-written abort/reset sequences and
// randomized runs checked against an arithmetic reference model.
module tb_fact_sequencer;

  localparam int W       = 16;
  localparam int TIMEOUT = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fact_sequencer_if #(.W(W)) bus ();

  fact_sequencer #(
    .W       (W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // ALU model configuration (written by the stimulus process only)
  int ack_wait  = 0;
  int ack_limit = -1;
  int ack_base  = 0;
  bit noise_en  = 1'b0;

  // ALU model observations (written by the ALU process only)
  int          acks_total = 0;
  int          req_total  = 0;
  int          req_run    = 0;
  int          last_run   = 0;
  int          unstable   = 0;
  int          fe_count   = 0;
  logic [15:0] last_a     = '0;
  logic [15:0] last_b     = '0;
  int          b_log[$];

  typedef struct {
    int n;
    int w;
    int lim;
    int edge_e;
    int res_e;
    int ovf_e;
    int err_e;
  } vec_t;

  vec_t tbl[10];

  // Shared ALU multiplier: acks the (ack_wait+1)-th request cycle, optionally only
  // for the first ack_limit multiplies of a run; random junk on the ack lines when idle.
  always @(negedge clk) begin : alu
    logic [31:0] prod;
    if (bus.mul_req) begin
      if (req_run > 0 && (bus.mul_a !== last_a || bus.mul_b !== last_b)) unstable++;
      last_a = bus.mul_a;
      last_b = bus.mul_b;
      req_run++;
      req_total++;
      if ((ack_limit < 0 || acks_total - ack_base < ack_limit) && req_run - 1 == ack_wait) begin
        prod           = 32'(bus.mul_a) * 32'(bus.mul_b);
        bus.mul_ack    = 1'b1;
        bus.mul_result = prod[15:0];
        bus.mul_ovf    = (prod > 32'd65535);
        acks_total++;
        b_log.push_back(int'(bus.mul_b));
      end else begin
        bus.mul_ack    = 1'b0;
        bus.mul_result = 16'($urandom);
        bus.mul_ovf    = 1'($urandom);
      end
    end else begin
      if (req_run > 0) last_run = req_run;
      req_run        = 0;
      bus.mul_ack    = noise_en & 1'($urandom_range(0, 1));
      bus.mul_result = 16'($urandom);
      bus.mul_ovf    = 1'($urandom);
    end
    if (bus.fact_end) fe_count++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Counts rising edges after FACT was raised until FACT_END is seen (-1 if never).
  task automatic wait_end(output int edge_o);
    edge_o = -1;
    for (int k = 1; k <= 1200; k++) begin
      @(negedge clk);
      if (bus.fact_end) begin
        edge_o = k;
        break;
      end
    end
  endtask

  task automatic run_op(input int n, input int w, input int lim, input bit noise,
                        output int edge_o, output int res_o, output int ovf_o,
                        output int err_o);
    @(negedge clk);
    ack_wait    = w;
    ack_limit   = lim;
    noise_en    = noise;
    ack_base    = acks_total;
    bus.operand = 16'(n);
    bus.fact    = 1'b1;
    wait_end(edge_o);
    res_o    = int'(bus.result);
    ovf_o    = int'(bus.ovf);
    err_o    = int'(bus.err);
    bus.fact = 1'b0;
    @(negedge clk);
    check("fact_end_width", bus.fact_end, 0);
    check("result_hold", bus.result, res_o);
    @(negedge clk);
    check("idle_after_hold", bus.busy, 0);
  endtask

  // Reference: product chain n*(n-1)*...*2 in W-bit arithmetic, each multiply costing
  // two cycles plus its ack wait; a missing ack costs TIMEOUT cycles and ends the run.
  function automatic void model(input int n, input int w, input int lim,
                                output int edge_o, output int res_o,
                                output int ovf_o, output int err_o);
    longint acc  = 1;
    longint prod;
    int     done = 0;
    edge_o = 1;
    ovf_o  = 0;
    err_o  = 0;
    for (int f = n; f >= 2; f--) begin
      if ((lim >= 0 && done >= lim) || w >= TIMEOUT) begin
        err_o  = 1;
        edge_o = edge_o + 1 + TIMEOUT;
        break;
      end
      prod = acc * f;
      if (prod > 65535) ovf_o = 1;
      acc    = prod % 65536;
      edge_o = edge_o + 2 + w;
      done++;
    end
    if (err_o == 0) edge_o = edge_o + 1;
    res_o = int'(acc);
  endfunction

  initial begin
    int e, r, o, er;
    int base, req0, prev, fe0, found;
    int me, mr, mo, merr;
    int n, w, lim, sel;
    bit noise;

    bus.fact    = 1'b0;
    bus.operand = '0;

    tbl[0] = '{5, 0, -1, 10, 120, 0, 0};
    tbl[1] = '{0, 0, -1, 2, 1, 0, 0};
    tbl[2] = '{1, 0, -1, 2, 1, 0, 0};
    tbl[3] = '{9, 0, -1, 18, 35200, 1, 0};
    tbl[4] = '{4, 0, 1, 68, 4, 0, 1};
    tbl[5] = '{3, 2, -1, 10, 6, 0, 0};
    tbl[6] = '{8, 1, -1, 23, 40320, 0, 0};
    tbl[7] = '{2, 63, -1, 67, 2, 0, 0};
    tbl[8] = '{2, 64, -1, 66, 1, 0, 1};
    tbl[9] = '{7, 0, -1, 14, 5040, 0, 0};

    // Reset state
    #22;
    check("reset_ctrl", {bus.mul_req, bus.busy, bus.fact_end, bus.ovf, bus.err}, 0);
    check("reset_result", bus.result, 0);
    check("reset_mul_bus", {bus.mul_a, bus.mul_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // n=5: multiplier sees 5,4,3,2
    base = b_log.size();
    run_op(5, 0, -1, 1'b0, e, r, o, er);
    check("n5_end_edge", e, 10);
    check("n5_mul_count", b_log.size() - base, 4);
    for (int i = 0; i < 4 && base + i < b_log.size(); i++) begin
      check("n5_mul_b_seq", b_log[base + i], 5 - i);
    end

    // n=0 and n=1 never request the multiplier
    req0 = req_total;
    run_op(0, 0, -1, 1'b0, e, r, o, er);
    check("n0_end_edge", e, 2);
    check("n0_result", r, 1);
    run_op(1, 0, -1, 1'b0, e, r, o, er);
    check("n1_end_edge", e, 2);
    check("n1_result", r, 1);
    check("n01_no_mul_req", req_total - req0, 0);

    // Table of hand-computed runs
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].n, tbl[i].w, tbl[i].lim, 1'b0, e, r, o, er);
      check("tbl_end_edge", e, tbl[i].edge_e);
      check("tbl_result", r, tbl[i].res_e);
      check("tbl_ovf", o, tbl[i].ovf_e);
      check("tbl_err", er, tbl[i].err_e);
      if (i == 4) check("timeout_req_cycles", last_run, TIMEOUT);
    end

    // Drop FACT during the second multiply of n=6
    prev = int'(bus.result);
    @(negedge clk);
    ack_wait    = 3;
    ack_limit   = -1;
    noise_en    = 1'b0;
    bus.operand = 16'd6;
    bus.fact    = 1'b1;
    found       = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.mul_req && bus.mul_b == 16'd5) begin
        found = 1;
        break;
      end
    end
    check("abort_reach_mul2", found, 1);
    bus.fact = 1'b0;
    fe0      = fe_count;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_mul_req", bus.mul_req, 0);
    repeat (3) @(negedge clk);
    check("abort_no_fact_end", fe_count - fe0, 0);
    check("abort_result_kept", bus.result, prev);

    // Asynchronous reset mid-multiply, then restart with FACT still high
    @(negedge clk);
    ack_wait    = 5;
    bus.operand = 16'd6;
    bus.fact    = 1'b1;
    found       = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.mul_req) begin
        found = 1;
        break;
      end
    end
    check("rst_reach_mul", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_ctrl", {bus.mul_req, bus.busy}, 0);
    check("rst_async_result", bus.result, 0);
    @(negedge clk);
    ack_wait    = 0;
    bus.operand = 16'd3;
    rst_n       = 1'b1;
    wait_end(e);
    check("rst_restart_edge", e, 6);
    check("rst_restart_result", bus.result, 6);
    bus.fact = 1'b0;
    repeat (2) @(negedge clk);

    // Randomized runs against the reference model
    for (int i = 0; i < 25; i++) begin
      n   = int'($urandom_range(0, 12));
      sel = int'($urandom_range(0, 9));
      if (sel < 7) w = sel % 4;
      else if (sel == 7) w = TIMEOUT - 1;
      else w = TIMEOUT;
      lim   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n)) : -1;
      noise = 1'($urandom_range(0, 1));
      model(n, w, lim, me, mr, mo, merr);
      run_op(n, w, lim, noise, e, r, o, er);
      check("rnd_end_edge", e, me);
      check("rnd_result", r, mr);
      check("rnd_ovf", o, mo);
      check("rnd_err", er, merr);
    end

    check("mul_operands_stable", unstable, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
